// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// select encodings and the packed control-strobe bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // All per-cycle strobes/selects decoded from state, kept together so the
  // default-zero assignment covers every output in one place.
  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_src_imm;
    logic [2:0] alu_funct3;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
  } ctrl_t;

  // Opcodes that proceed to EXEC; SYSTEM is decoded separately as a halt.
  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side.
interface multicycle_ctrl_if #(parameter int RET_W = 32);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             alu_src_imm;
  logic [2:0]       alu_funct3;
  logic [1:0]       alu_op;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic             halted;
  logic             illegal;
  logic             bus_err;
  logic [RET_W-1:0] retired;

  modport master (
    input  opcode, funct3, branch_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm,
           alu_funct3, alu_op, rf_we, wb_sel, halted, illegal, bus_err, retired
  );

  modport slave (
    output opcode, funct3, branch_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm,
           alu_funct3, alu_op, rf_we, wb_sel, halted, illegal, bus_err, retired
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait; expired is raised in
// the cycle that would make the count reach MEM_TIMEOUT while still waiting.
// MEM_TIMEOUT = 0 disables the timeout entirely.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  generate
    if (MEM_TIMEOUT > 0) begin : g_tmr
      logic [CW-1:0] cnt;

      // Wait counter; clear has priority, saturates so it can never wrap.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                        cnt <= '0;
        else if (clear)                 cnt <= '0;
        else if (count_en && cnt != '1) cnt <= cnt + 1'b1;
      end

      assign expired = count_en && (cnt == CW'(MEM_TIMEOUT - 1));
    end else begin : g_no_tmr
      assign expired = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with trap on illegal
// opcode, SYSTEM or memory timeout, plus a retired-instruction counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);
  state_t           state, state_nx;
  ctrl_t            c;
  logic             illegal_q, bus_err_q;
  logic             illegal_set, bus_err_set;
  logic             tmr_en, tmr_clr, tmr_exp;
  logic [RET_W-1:0] retired_q;
  logic [6:0]       op;

  assign op = bus.opcode;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clr),
    .count_en (tmr_en),
    .expired  (tmr_exp)
  );

  // State, sticky trap causes and retire counter (one retire per pc_we).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_nx;
      if (illegal_set) illegal_q <= 1'b1;
      if (bus_err_set) bus_err_q <= 1'b1;
      if (c.pc_we)     retired_q <= retired_q + RET_W'(1);
    end
  end

  // Next-state and strobe decode; everything defaults to zero/hold.
  always_comb begin
    c           = '0;
    state_nx    = state;
    illegal_set = 1'b0;
    bus_err_set = 1'b0;
    tmr_en      = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        c.imem_req = 1'b1;
        tmr_en     = !bus.imem_ready;
        if (bus.imem_ready) begin
          c.ir_we  = 1'b1;
          state_nx = S_DECODE;
        end else if (tmr_exp) begin
          state_nx    = S_TRAP;
          bus_err_set = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal(op)) begin
          state_nx = S_EXEC;
        end else begin
          state_nx    = S_TRAP;
          illegal_set = (op != OP_SYSTEM);
        end
      end
      S_EXEC: begin
        c.alu_src_imm = op inside {OP_I, OP_LOAD, OP_STORE, OP_JALR, OP_LUI, OP_AUIPC};
        if (op == OP_R || op == OP_I) c.alu_op = ALU_FUNCT;
        else if (op == OP_BRANCH)     c.alu_op = ALU_CMP;
        else                          c.alu_op = ALU_ADD;
        c.alu_funct3 = (c.alu_op == ALU_FUNCT) ? bus.funct3 : 3'b000;
        if (op == OP_BRANCH) begin
          c.pc_we  = 1'b1;
          c.pc_sel = bus.branch_taken ? PC_REL : PC_PLUS4;
          state_nx = S_FETCH;
        end else if (op == OP_LOAD || op == OP_STORE) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        c.dmem_req = 1'b1;
        c.dmem_we  = (op == OP_STORE);
        tmr_en     = !bus.dmem_ready;
        if (bus.dmem_ready) begin
          if (op == OP_STORE) begin
            c.pc_we  = 1'b1;
            c.pc_sel = PC_PLUS4;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else if (tmr_exp) begin
          state_nx    = S_TRAP;
          bus_err_set = 1'b1;
        end
      end
      S_WB: begin
        c.rf_we  = 1'b1;
        c.pc_we  = 1'b1;
        c.wb_sel = (op == OP_LOAD) ? WB_LOAD :
                   (op == OP_JAL || op == OP_JALR) ? WB_PC4 : WB_ALU;
        c.pc_sel = (op == OP_JAL) ? PC_REL : (op == OP_JALR) ? PC_JALR : PC_PLUS4;
        state_nx = S_FETCH;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_IDLE;
    endcase
    // Wait timer restarts whenever the FSM leaves its current state.
    tmr_clr = (state_nx != state);
  end

  assign bus.imem_req    = c.imem_req;
  assign bus.dmem_req    = c.dmem_req;
  assign bus.dmem_we     = c.dmem_we;
  assign bus.ir_we       = c.ir_we;
  assign bus.pc_we       = c.pc_we;
  assign bus.pc_sel      = c.pc_sel;
  assign bus.alu_src_imm = c.alu_src_imm;
  assign bus.alu_funct3  = c.alu_funct3;
  assign bus.alu_op      = c.alu_op;
  assign bus.rf_we       = c.rf_we;
  assign bus.wb_sel      = c.wb_sel;
  assign bus.halted      = (state == S_TRAP);
  assign bus.illegal     = illegal_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.retired     = retired_q;
endmodule
